rgb_pwm_driver: RTL and testbench
=================================

RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

Interface
REQ-001 Parameter PRESCALE, default 1, meaning clock cycles per PWM step; legal range 1..65535.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  high = drive LEDs; low = all LEDs off and counters held at zero.
REQ-005 rgb  input  24  colour from the upstream RGB converter; [23:16] red, [15:8] green, [7:0] blue duty values.
REQ-006 led_r  output  1  red PWM output, registered.
REQ-007 led_g  output  1  green PWM output, registered.
REQ-008 led_b  output  1  blue PWM output, registered.
REQ-009 frame_start  output  1  one-cycle pulse marking display of step 0 of a new frame, registered.

Function
REQ-010 The block SHALL keep a prescaler counter pre (0..PRESCALE-1) and a step counter step (0..254); one frame = 255 steps = 255*PRESCALE cycles.
REQ-011 On an edge with enable=1: if pre==PRESCALE-1 then pre<=0 and step advances (254 wraps to 0), else pre<=pre+1 and step holds.
REQ-012 On an edge with enable=1 and (pre,step)==(0,0), the block SHALL latch rgb into a 24-bit shadow register; this is the only point at which new colour data is accepted.
REQ-013 On every edge with enable=1, each led_x SHALL be loaded with (step < duty_x), where duty_x is the incoming rgb field on a frame-boundary edge (REQ-012) and the shadow field otherwise; latency from rgb sample to first LED level = 1 cycle.
REQ-014 Duty 0 SHALL give a constantly low output; duty 255 SHALL give a constantly high output; duty N SHALL give exactly N*PRESCALE high cycles per frame.
REQ-015 Changes on rgb between frame boundaries SHALL have no effect on outputs until the next frame boundary (glitch-free update).
REQ-016 frame_start SHALL be loaded with 1 on a frame-boundary edge (REQ-012) and 0 on every other edge.
REQ-017 On an edge with enable=0: pre<=0, step<=0, led_r/g/b<=0, frame_start<=0; the shadow register holds its value.
REQ-018 Enable rising after a low period SHALL start a fresh frame: the first enabled edge is a frame boundary (counters at 0,0) and samples rgb.
REQ-019 Enable dropping mid-frame SHALL abort the frame; outputs go low one cycle later with no partial completion.
REQ-020 With PRESCALE=1, the prescaler SHALL be permanently zero and step SHALL advance every enabled edge.

Reset
REQ-021 On an edge with rst=1 (priority over enable): pre<=0, step<=0, shadow<=24'h000000, led_r/g/b<=0, frame_start<=0.
REQ-022 rst asserted mid-frame SHALL abort the frame; the first edge with rst=0 and enable=1 SHALL be a frame boundary.

Structure
REQ-023 Shared constants header SHALL hold PWM_STEPS (255), the channel bit-slice positions (R 23:16, G 15:8, B 7:0) and the default PRESCALE.
REQ-024 The block SHALL instantiate one sub-module, pwm_channel (8-bit duty in, step in, frame-boundary select, shadow byte, registered output), three times, once per colour.
REQ-025 Counters and frame_start logic SHALL live in rgb_pwm_driver itself; a competent implementation is 120-400 RTL lines.

Verification
REQ-026 PRESCALE=1, rst then enable=1, rgb=24'hFF0080 -> over the 255 cycles after the first enabled edge, led_r high 255, led_g high 0, led_b high 128 cycles, led_b high for exactly the first 128; frame_start pulses every 255 cycles.
REQ-027 PRESCALE=4, rgb=24'h010203 -> frame_start period 1020 cycles; led_r/g/b high 4/8/12 cycles per frame, each beginning in the frame_start cycle.
REQ-028 PRESCALE=1, rgb=24'h404040, then rgb changed to 24'hC0C0C0 at step 100 -> current frame keeps 64-cycle duty; next frame shows 192-cycle duty.
REQ-029 enable dropped at step 50 for 10 cycles -> all LEDs and frame_start 0 one cycle after the drop; on re-enable, frame_start pulses on the first enabled edge and the step count restarts at 0.
REQ-030 rst pulsed for 1 cycle mid-frame with enable=1 -> all outputs 0 in the following cycle; the next edge restarts the frame with frame_start=1; the shadow is reloaded from the current rgb.
REQ-031 Boundary check: duty 0 and 255 on all channels over 3 frames -> outputs constantly 0 and constantly 1 respectively, with no glitch at the wrap from step 254 to 0.

Source files
------------

// File: rtl/rgb_pwm_driver_pkg.sv
// Shared constants for the RGB PWM driver: frame length, counter widths
// and the colour channel positions within the 24-bit rgb word.
package rgb_pwm_driver_pkg;

    localparam int unsigned PWM_STEPS        = 255;
    localparam int unsigned STEP_W           = 8;
    localparam int unsigned PRE_W            = 16;
    localparam int unsigned DUTY_W           = 8;
    localparam int unsigned RGB_W            = 24;
    localparam int unsigned DEFAULT_PRESCALE = 1;

    localparam int unsigned R_MSB = 23;
    localparam int unsigned R_LSB = 16;
    localparam int unsigned G_MSB = 15;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_MSB = 7;
    localparam int unsigned B_LSB = 0;

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One colour channel: holds the frame's duty in a shadow byte and drives a
// registered LED level of (step < duty).
module pwm_channel
    import rgb_pwm_driver_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              frame_bnd_i,
    input  logic [DUTY_W-1:0] duty_i,
    input  logic [STEP_W-1:0] step_i,
    output logic              led_o
);

    logic [DUTY_W-1:0] shadow_q, shadow_d;
    logic [DUTY_W-1:0] duty_sel_c;
    logic              led_q, led_d;

    // On a frame boundary the incoming duty is used directly so the new
    // colour is visible on step 0 without waiting for the shadow load.
    always_comb begin
        shadow_d   = shadow_q;
        led_d      = 1'b0;
        duty_sel_c = frame_bnd_i ? duty_i : shadow_q;
        if (enable_i) begin
            if (frame_bnd_i) begin
                shadow_d = duty_i;
            end
            led_d = (step_i < duty_sel_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            led_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            led_q    <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel LED PWM driver: prescaler and step counters, frame-start
// pulse, and one pwm_channel per colour.
module rgb_pwm_driver
    import rgb_pwm_driver_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [RGB_W-1:0] rgb,
    output logic             led_r,
    output logic             led_g,
    output logic             led_b,
    output logic             frame_start
);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PWM_STEPS - 1);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              fs_q, fs_d;
    logic              frame_bnd_c;

    // Counters only run while enabled; disabling parks them at (0,0) so the
    // next enabled edge is always a frame boundary.
    always_comb begin
        pre_d       = '0;
        step_d      = '0;
        fs_d        = 1'b0;
        frame_bnd_c = enable && (pre_q == '0) && (step_q == '0);
        if (enable) begin
            fs_d = frame_bnd_c;
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                step_d = (step_q == STEP_LAST) ? '0 : step_q + STEP_W'(1);
            end else begin
                pre_d  = pre_q + PRE_W'(1);
                step_d = step_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            step_q <= '0;
            fs_q   <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            step_q <= step_d;
            fs_q   <= fs_d;
        end
    end

    assign frame_start = fs_q;

    pwm_channel u_ch_r (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable),
        .frame_bnd_i (frame_bnd_c),
        .duty_i      (rgb[R_MSB:R_LSB]),
        .step_i      (step_q),
        .led_o       (led_r)
    );

    pwm_channel u_ch_g (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable),
        .frame_bnd_i (frame_bnd_c),
        .duty_i      (rgb[G_MSB:G_LSB]),
        .step_i      (step_q),
        .led_o       (led_g)
    );

    pwm_channel u_ch_b (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable),
        .frame_bnd_i (frame_bnd_c),
        .duty_i      (rgb[B_MSB:B_LSB]),
        .step_i      (step_q),
        .led_o       (led_b)
    );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench for rgb_pwm_driver: PRESCALE=1 and PRESCALE=4 instances,
// cycle-stamped output expectations plus per-frame high-count expectations.
module tb_rgb_pwm_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        en0, en1;
    logic [23:0] rgb0, rgb1;
    logic        r0, g0, b0, f0;
    logic        r1, g1, b1, f1;

    always #5 clk = ~clk;

    rgb_pwm_driver #(.PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .enable(en0), .rgb(rgb0),
        .led_r(r0), .led_g(g0), .led_b(b0), .frame_start(f0)
    );

    rgb_pwm_driver #(.PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .enable(en1), .rgb(rgb1),
        .led_r(r1), .led_g(g1), .led_b(b1), .frame_start(f1)
    );

    typedef struct {
        int         cyc;
        int         d;
        logic [3:0] v;
        string      name;
    } pt_t;

    typedef struct {
        int r;
        int g;
        int b;
        int len;
    } fr_t;

    pt_t pq[$];
    fr_t fq0[$];
    fr_t fq1[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit   active [2];
    int   len    [2];
    int   cnt    [2][3];
    bit   low    [2][3];
    bit   pbad   [2];
    logic [3:0] act;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic pt(input int c, input int d, input logic [3:0] v, input string nm);
        pt_t e;
        e.cyc = c; e.d = d; e.v = v; e.name = nm;
        pq.push_back(e);
    endtask

    task automatic fr(input int d, input int r, input int g, input int b, input int l);
        fr_t e;
        e.r = r; e.g = g; e.b = b; e.len = l;
        if (d == 0) fq0.push_back(e);
        else        fq1.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_cmp(input int d);
        fr_t e;
        total++;
        if ((d == 0 && fq0.size() == 0) || (d == 1 && fq1.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_frame dut%0d cyc=%0d got r/g/b/len=%0d/%0d/%0d/%0d want none",
                     d, cyc, cnt[d][0], cnt[d][1], cnt[d][2], len[d]);
        end else begin
            if (d == 0) e = fq0.pop_front();
            else        e = fq1.pop_front();
            if (cnt[d][0] != e.r || cnt[d][1] != e.g || cnt[d][2] != e.b ||
                len[d] != e.len || pbad[d]) begin
                bad++;
                $display("FAIL frame dut%0d cyc=%0d got r/g/b/len/gap=%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/0",
                         d, cyc, cnt[d][0], cnt[d][1], cnt[d][2], len[d], pbad[d],
                         e.r, e.g, e.b, e.len);
            end
        end
    endtask

    // Each frame is closed by the next frame_start; highs must form a prefix.
    task automatic mon_step(input int d, input logic [3:0] v);
        if (v[3] === 1'b1) begin
            if (active[d]) frame_cmp(d);
            active[d] = 1'b1;
            len[d]    = 0;
            pbad[d]   = 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                cnt[d][ch] = 0;
                low[d][ch] = 1'b0;
            end
        end
        if (active[d]) begin
            len[d]++;
            for (int ch = 0; ch < 3; ch++) begin
                if (v[2-ch] === 1'b1) begin
                    cnt[d][ch]++;
                    if (low[d][ch]) pbad[d] = 1'b1;
                end else begin
                    low[d][ch] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_step(0, {f0, r0, g0, b0});
            mon_step(1, {f1, r1, g1, b1});
            for (int i = pq.size() - 1; i >= 0; i--) begin
                if (pq[i].cyc == cyc) begin
                    act = (pq[i].d == 0) ? {f0, r0, g0, b0} : {f1, r1, g1, b1};
                    total++;
                    if (act !== pq[i].v) begin
                        bad++;
                        $display("FAIL %s dut%0d cyc=%0d got fs/r/g/b=%b want %b",
                                 pq[i].name, pq[i].d, cyc, act, pq[i].v);
                    end
                    pq.delete(i);
                end
            end
        end
    end

    initial begin
        rst  = 1'b1;
        en0  = 1'b0;
        en1  = 1'b0;
        rgb0 = 24'h000000;
        rgb1 = 24'h010203;

        pt(2, 0, 4'b0000, "reset_p1");
        pt(2, 1, 4'b0000, "reset_p4");
        wait_cyc(2);
        rst  = 1'b0;
        en0  = 1'b1;
        en1  = 1'b1;
        rgb0 = 24'hFF0080;

        pt(3,   0, 4'b1101, "ff0080_step0");
        pt(4,   0, 4'b0101, "ff0080_step1");
        pt(130, 0, 4'b0101, "blue_step127");
        pt(131, 0, 4'b0100, "blue_step128");
        fr(0, 255, 0, 128, 255);

        pt(3,    1, 4'b1111, "p4_step0_first");
        pt(6,    1, 4'b0111, "p4_step0_last");
        pt(7,    1, 4'b0011, "p4_step1");
        pt(11,   1, 4'b0001, "p4_step2");
        pt(15,   1, 4'b0000, "p4_step3");
        pt(1023, 1, 4'b1111, "p4_frame2_start");
        pt(1026, 1, 4'b0111, "p4_frame2_step0_last");
        fr(1, 4, 8, 12, 1020);
        fr(1, 4, 8, 12, 1020);

        // Mid-frame colour changes must wait for the next boundary.
        wait_cyc(3);
        rgb0 = 24'h404040;
        fr(0, 64, 64, 64, 255);
        wait_cyc(358);
        rgb0 = 24'hC0C0C0;
        fr(0, 192, 192, 192, 255);

        wait_cyc(600);
        rgb0 = 24'h000000;
        fr(0, 0, 0, 0, 255);
        fr(0, 0, 0, 0, 255);
        fr(0, 0, 0, 0, 255);
        pt(1022, 0, 4'b0000, "duty0_step254");
        pt(1023, 0, 4'b1000, "duty0_wrap");

        wait_cyc(1400);
        rgb0 = 24'hFFFFFF;
        fr(0, 255, 255, 255, 255);
        fr(0, 255, 255, 255, 255);
        fr(0, 255, 255, 255, 255);
        pt(1532, 0, 4'b0000, "duty0_last");
        pt(1533, 0, 4'b1111, "duty255_first");
        pt(2042, 0, 4'b0111, "duty255_step254");
        pt(2043, 0, 4'b1111, "duty255_wrap");

        wait_cyc(2100);
        en1  = 1'b0;
        rgb0 = 24'h404040;
        pt(2348, 0, 4'b0111, "before_disable");
        pt(2349, 0, 4'b0000, "after_disable");
        pt(2358, 0, 4'b0000, "disabled_last");
        pt(2359, 0, 4'b1111, "reenable_start");
        pt(2422, 0, 4'b0111, "reenable_step63");
        pt(2423, 0, 4'b0000, "reenable_step64");
        fr(0, 51, 51, 51, 61);
        fr(0, 64, 64, 64, 255);
        pt(2644, 0, 4'b0111, "before_rst");
        pt(2645, 0, 4'b0000, "after_rst");
        pt(2646, 0, 4'b1111, "rst_restart");
        pt(2837, 0, 4'b0111, "c0_step191");
        pt(2838, 0, 4'b0000, "c0_step192");
        fr(0, 31, 31, 31, 32);
        fr(0, 192, 192, 192, 255);

        wait_cyc(2348);
        en0 = 1'b0;
        wait_cyc(2358);
        en0 = 1'b1;

        wait_cyc(2620);
        rgb0 = 24'hC0C0C0;
        wait_cyc(2644);
        rst = 1'b1;
        wait_cyc(2645);
        rst = 1'b0;

        wait_cyc(2910);
        foreach (pq[i]) begin
            total++;
            bad++;
            $display("FAIL %s dut%0d never checked at cyc=%0d want %b",
                     pq[i].name, pq[i].d, pq[i].cyc, pq[i].v);
        end
        foreach (fq0[i]) begin
            total++;
            bad++;
            $display("FAIL missing_frame dut0 got none want r/g/b/len=%0d/%0d/%0d/%0d",
                     fq0[i].r, fq0[i].g, fq0[i].b, fq0[i].len);
        end
        foreach (fq1[i]) begin
            total++;
            bad++;
            $display("FAIL missing_frame dut1 got none want r/g/b/len=%0d/%0d/%0d/%0d",
                     fq1[i].r, fq1[i].g, fq1[i].b, fq1[i].len);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
